// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder (target) for the peripheral bus.
//
// An external master drives spi_cs/spi_clk/spi_mosi. All three are
// resynchronised into raw_clk. Received bytes go to a receive store for the
// CPU, and CPU-supplied bytes are returned on spi_miso, MSB first.
//
// Optional feature (macro SPI_TARGET_RX_FIFO_EN):
//   undefined - the receive store is a single byte register
//   defined   - the receive store is a 4-entry FIFO
//
// Parameters:
//   SYNC_STAGES    synchroniser depth on the SPI pins (2 or 3)
// Ports:
//   raw_clk        system clock
//   reset          synchronous, active-high reset
//   spi_cs         chip select, active low, asynchronous
//   spi_clk        SPI clock, idle low, asynchronous
//   spi_mosi       serial data from master, MSB first
//   spi_miso       serial data to master, MSB first (1 while idle)
//   tx_data        next byte to return to the master
//   tx_load        strobe: write tx_data into the holding register
//   tx_empty       holding register free
//   rx_data        oldest received byte
//   rx_ready       at least one received byte pending
//   rx_ready_clear strobe: consume rx_data and clear rx_overrun
//   rx_overrun     sticky: a completed byte was dropped
//   busy           transaction in progress
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ready_clear,
    output logic       rx_overrun,
    output logic       busy
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // Synchronisers reset to 0 so a CS already low at reset release never
    // produces a falling edge, and a high CS is only seen once really high.
    logic [SYNC_STAGES-1:0] cs_sync_q, clk_sync_q, mosi_sync_q;
    logic                   cs_hist_q, clk_hist_q;
    logic                   cs_s, clk_s, mosi_s;
    logic                   cs_fall, cs_rise, clk_rise, clk_fall;

    state_e     state_q;
    logic       armed_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_shift_q;
    logic [7:0] tx_shift_q;
    logic       reload_q;
    logic [7:0] tx_hold_q;
    logic       tx_empty_q;

    logic       start_load, active_load, shifter_load;
    logic [7:0] load_byte;
    logic [7:0] push_byte;
    logic       push;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_fall  = cs_hist_q & ~cs_s;
    assign cs_rise  = ~cs_hist_q & cs_s;
    assign clk_rise = ~clk_hist_q & clk_s;
    assign clk_fall = clk_hist_q & ~clk_s;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            cs_sync_q   <= '0;
            clk_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_hist_q   <= 1'b0;
            clk_hist_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_hist_q   <= cs_s;
            clk_hist_q  <= clk_s;
        end
    end

    // Shifter loads happen at transaction start and on the falling edge
    // that follows each completed byte.
    assign start_load   = (state_q == StIdle) && cs_fall && armed_q;
    assign active_load  = (state_q == StActive) && !cs_rise && clk_fall && reload_q;
    assign shifter_load = start_load | active_load;
    assign load_byte    = tx_empty_q ? 8'hFF : tx_hold_q;

    assign push_byte = {rx_shift_q, mosi_s};
    assign push      = (state_q == StActive) && !cs_rise && clk_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            tx_shift_q <= 8'hFF;
            reload_q   <= 1'b0;
        end else begin
            if (cs_s) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_load) begin
                        state_q    <= StActive;
                        bit_cnt_q  <= 3'd0;
                        reload_q   <= 1'b0;
                        tx_shift_q <= load_byte;
                    end
                end
                StActive: begin
                    if (cs_rise) begin
                        // Any partial byte is simply abandoned.
                        state_q    <= StIdle;
                        bit_cnt_q  <= 3'd0;
                        reload_q   <= 1'b0;
                        tx_shift_q <= 8'hFF;
                    end else begin
                        if (clk_rise) begin
                            rx_shift_q <= push_byte[6:0];
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                reload_q <= 1'b1;
                            end
                        end
                        if (clk_fall) begin
                            if (reload_q) begin
                                tx_shift_q <= load_byte;
                                reload_q   <= 1'b0;
                            end else begin
                                tx_shift_q <= {tx_shift_q[6:0], 1'b1};
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Holding register: a load in the same cycle as a shifter load wins, the
    // shifter still takes the old byte.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            tx_hold_q  <= 8'h00;
            tx_empty_q <= 1'b1;
        end else if (tx_load) begin
            tx_hold_q  <= tx_data;
            tx_empty_q <= 1'b0;
        end else if (shifter_load) begin
            tx_empty_q <= 1'b1;
        end
    end

    assign spi_miso = tx_shift_q[7];
    assign tx_empty = tx_empty_q;
    assign busy     = (state_q == StActive);

`ifdef SPI_TARGET_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       rx_overrun_q;
    logic       pop, accept;

    assign pop    = rx_ready_clear && (count_q != 3'd0);
    // A pop in the same cycle frees the slot the push needs.
    assign accept = push && ((count_q != 3'd4) || pop);

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 8'h00;
            end
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= push_byte;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            if (accept && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (pop && !accept) begin
                count_q <= count_q - 3'd1;
            end
            if (rx_ready_clear) begin
                rx_overrun_q <= 1'b0;
            end
            if (push && !accept) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    assign rx_data    = fifo_q[rd_ptr_q];
    assign rx_ready   = (count_q != 3'd0);
    assign rx_overrun = rx_overrun_q;
`else
    logic [7:0] rx_data_q;
    logic       rx_ready_q;
    logic       rx_overrun_q;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            rx_data_q    <= 8'h00;
            rx_ready_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (rx_ready_clear) begin
                rx_overrun_q <= 1'b0;
            end
            if (push) begin
                // A simultaneous clear frees the register for the new byte.
                if (!rx_ready_q || rx_ready_clear) begin
                    rx_data_q  <= push_byte;
                    rx_ready_q <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (rx_ready_clear) begin
                rx_ready_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_ready   = rx_ready_q;
    assign rx_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
module tb_spi_target;

    localparam int unsigned SyncStages = 2;
`ifdef SPI_TARGET_RX_FIFO_EN
    localparam int RxCap = 4;
`else
    localparam int RxCap = 1;
`endif

    logic       raw_clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ready_clear = 1'b0;
    logic       rx_overrun;
    logic       busy;

    spi_target #(.SYNC_STAGES(SyncStages)) u_dut (
        .raw_clk       (raw_clk),
        .reset         (reset),
        .spi_cs        (spi_cs),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .tx_data       (tx_data),
        .tx_load       (tx_load),
        .tx_empty      (tx_empty),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .rx_ready_clear(rx_ready_clear),
        .rx_overrun    (rx_overrun),
        .busy          (busy)
    );

    always #5 raw_clk = ~raw_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte-level view of holding register and receive store.
    logic [7:0] m_hold;
    bit         m_empty;
    logic [7:0] m_rx[$];
    bit         m_ovr;
    logic [7:0] exp_tx;
    logic [7:0] mosi_bytes[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge raw_clk);
    endtask

    task automatic m_take(output logic [7:0] b);
        b = m_empty ? 8'hFF : m_hold;
        m_empty = 1'b1;
    endtask

    task automatic m_push(input logic [7:0] b);
        if (m_rx.size() < RxCap) m_rx.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        m_hold = 8'h00;
        m_empty = 1'b1;
        m_rx.delete();
        m_ovr = 1'b0;
        cyc(8);
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        m_hold = b;
        m_empty = 1'b0;
        cyc(1);
    endtask

    task automatic rx_pop();
        rx_ready_clear = 1'b1;
        cyc(1);
        rx_ready_clear = 1'b0;
        if (m_rx.size() > 0) void'(m_rx.pop_front());
        m_ovr = 1'b0;
        cyc(1);
    endtask

    // Drops CS; optionally lands a tx_load on the very cycle the DUT acts on it.
    task automatic frame_begin(input bit coincide, input logic [7:0] ld);
        spi_cs = 1'b0;
        m_take(exp_tx);
        if (coincide) begin
            cyc(SyncStages);
            tx_data = ld;
            tx_load = 1'b1;
            cyc(1);
            tx_load = 1'b0;
            m_hold = ld;
            m_empty = 1'b0;
            cyc(7 - SyncStages);
        end else begin
            cyc(8);
        end
        check("busy_active", busy, 1);
    endtask

    task automatic frame_bits(input int nbits, input bit live);
        logic [7:0] mi;
        logic [7:0] mo;
        int k;
        mi = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            k = b % 8;
            mo = mosi_bytes[b / 8];
            spi_mosi = mo[7-k];
            cyc(8);
            mi[7-k] = spi_miso;
            spi_clk = 1'b1;
            cyc(8);
            spi_clk = 1'b0;
            if (k == 7 && live) begin
                check("miso_byte", mi, exp_tx);
                m_push(mo);
                m_take(exp_tx);
            end
        end
        cyc(8);
    endtask

    task automatic frame_end();
        spi_cs = 1'b1;
        cyc(12);
        check("busy_idle", busy, 0);
        check("miso_idle", spi_miso, 1);
    endtask

    task automatic post_check();
        check("rx_ready", rx_ready, (m_rx.size() > 0) ? 1 : 0);
        check("rx_overrun", rx_overrun, m_ovr);
        check("tx_empty", tx_empty, m_empty);
        if (m_rx.size() > 0) check("rx_data", rx_data, m_rx[0]);
    endtask

    task automatic drain();
        while (m_rx.size() > 0) begin
            check("drain_data", rx_data, m_rx[0]);
            rx_pop();
        end
        post_check();
    endtask

    task automatic run_frame(input int nbits);
        frame_begin(1'b0, 8'h00);
        frame_bits(nbits, 1'b1);
        frame_end();
        post_check();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        cyc(1);
        do_reset();
        check("rst_miso", spi_miso, 1);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_rx_overrun", rx_overrun, 0);
        check("rst_busy", busy, 0);

        // Single byte: A5 out, 3C in.
        tx_write(8'hA5);
        mosi_bytes = '{8'h3C};
        run_frame(8);
        check("t1_rx_data", rx_data, 8'h3C);
        drain();

        // Two bytes with nothing loaded: all ones out, overrun without FIFO.
        mosi_bytes = '{8'h01, 8'h02};
        run_frame(16);
        drain();

        // Five bytes without pops.
        mosi_bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        run_frame(40);
        check("t3_overrun", rx_overrun, 1);
        rx_pop();
        post_check();
        drain();

        // Partial byte is discarded, next full frame lands.
        mosi_bytes = '{8'hFF};
        run_frame(5);
        check("t4_no_push", rx_ready, 0);
        mosi_bytes = '{8'h81};
        run_frame(8);
        check("t4_rx_data", rx_data, 8'h81);
        drain();

        // CS held low across reset release: frame ignored until CS goes high.
        spi_cs = 1'b0;
        do_reset();
        mosi_bytes = '{8'hC3};
        frame_bits(8, 1'b0);
        check("t5_ignored_ready", rx_ready, 0);
        check("t5_ignored_busy", busy, 0);
        spi_cs = 1'b1;
        cyc(12);
        mosi_bytes = '{8'h5A};
        run_frame(8);
        check("t5_rx_data", rx_data, 8'h5A);
        drain();

        // tx_load coinciding with the CS-fall shifter load.
        tx_write(8'h22);
        mosi_bytes = '{8'h77, 8'h88};
        frame_begin(1'b1, 8'h11);
        check("t6_tx_empty", tx_empty, 0);
        frame_bits(16, 1'b1);
        frame_end();
        post_check();
        drain();

        // Randomised frames, loads and pops.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(1, 0) == 1) tx_write(8'($urandom()));
            mosi_bytes.delete();
            for (int j = 0; j < 3; j++) mosi_bytes.push_back(8'($urandom()));
            run_frame(int'($urandom_range(24, 1)));
            repeat ($urandom_range(2, 0)) rx_pop();
            post_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
